stack_pop_seq: RTL and testbench
================================

# stack_pop_seq

Multi-cycle stack pop sequencer for the V30-compatible core. Takes the 16-bit `pop` mask produced by pre-decode (POP reg/sreg/PSW/mem, POP R, RET, RETF, RETI, RET imm) and issues one word read per set bit at SS:SP. Each returned word goes to the register file or the MODRM writer. At the end it applies the optional immediate SP adjust and hands back the final SP. It sits between the execute stage and the bus interface unit, and is the read-side counterpart of the push path.

## Interface
Parameters:
- `ADDR_W`, default 20: physical address width; addresses wrap modulo 2^ADDR_W.

Ports:
- `clk`  in  1  core clock; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a pop sequence; honoured only in IDLE.
- `pop_mask`  in  16  STACK_* bit mask; sampled with `start`.
- `ss`  in  16  stack segment; sampled with `start`.
- `sp_in`  in  16  current SP; sampled with `start`.
- `imm`  in  16  RET immediate; sampled with `start`.
- `mem_req`  out  1  word read request to the bus interface unit.
- `mem_addr`  out  ADDR_W  physical address (ss<<4)+sp.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  read data.
- `wr_en`  out  1  one-cycle write strobe for the popped word.
- `wr_sel`  out  4  bit index (0–15) of the mask bit that was serviced.
- `wr_data`  out  16  popped word.
- `sp_out`  out  16  running internal SP.
- `sp_we`  out  1  one-cycle strobe to commit `sp_out` to the register file.
- `busy`  out  1  high whenever not in IDLE.
- `done`  out  1  one-cycle completion pulse, coincident with `sp_we`.

## Operation
- States: IDLE, SCAN, REQ, ADJ, DONE.
- IDLE
  - On `start`: latch `pop_mask` into `rem`, and latch `ss`, `sp_in`, `imm`.
  - Next state is SCAN.
- SCAN
  - Select the highest set bit of `rem[14:0]`. Descending order gives pop order PC→PS→PSW, IY→IX→BP→SP→BW→DW→CW→AW, with MODRM first.
  - If a bit is found: register `mem_addr` and go to REQ.
  - If no bit is found: go to ADJ when `rem[15]` is set, otherwise go to DONE.
- REQ
  - Hold `mem_req` high with a stable `mem_addr` until `mem_ack`.
  - On `mem_ack`:
    - Register `wr_en`=1, `wr_sel`=index, `wr_data`=`mem_rdata`.
    - Clear the serviced bit in `rem`.
    - sp += 2, modulo 2^16.
    - Go to SCAN.
- STACK_SP bit (bit 4): the read is performed and SP advances, but `wr_en` stays 0. The value is discarded, as POP R requires.
- ADJ: sp += imm, modulo 2^16; clear `rem[15]`; go to DONE.
- DONE: pulse `done` and `sp_we`, then return to IDLE.
- Address arithmetic: zero-extend `ss` to ADDR_W, shift left 4, add the zero-extended sp, truncate to ADDR_W. With ss=FFFF and sp=0010 this gives 00000.
- `start` while busy is ignored and the latched mask is unaffected.
- Reset mid-operation: immediate return to IDLE, abandoning any pending `mem_req`. The bus unit drops an un-acked request when `mem_req` falls.

## Timing
- Reset values:
  - `mem_req`, `wr_en`, `sp_we`, `done`, `busy`: 0.
  - `mem_addr`, `wr_sel`, `wr_data`, `sp_out`: 0.
  - State: IDLE.
- `start` at cycle 0: `busy` at cycle 1 (SCAN), `mem_req` at cycle 2.
- Zero-wait ack (ack in the first REQ cycle): 2 cycles per popped word. `wr_en` is high the cycle after ack, overlapping the next SCAN.
- Empty mask: `done` at cycle 2.
- Total cycles = 2 + 2·(pops) + (imm ? 1 : 0) + Σ(wait states).
- All outputs are registered; no combinational path from `mem_ack` to `mem_req`.

## Configuration
- `STACK_POP_IMM_EN` defined: bit 15 (STACK_IMM) triggers the ADJ state and the `imm` input is used.
- Undefined: ADJ is removed, bit 15 is ignored, and `imm` is unused. A mask carrying only bit 15 completes like an empty mask.

## Structure
- Shared package `types` gains:
  - `pop_state_e` (IDLE, SCAN, REQ, ADJ, DONE).
  - `stack_bit_e`: 4-bit indices matching the existing STACK_* mask constants.
- Sub-module `stack_mask_prio`: combinational 15-bit highest-set-bit encoder with outputs `found` and `idx[3:0]`. It is shared with the future push sequencer, which uses it with reversed order.

## Test plan
- Single pop: mask 0002, ss=1000, sp=FFFE, rdata=ABCD.
  - `mem_addr`=1FFFE; `wr_sel`=1, `wr_data`=ABCD.
  - `sp_out`=0000 (wraps); `done` at cycle 4.
- RETI: mask 2600, sp=0100, rdata 1111/2222/3333, 2 wait states each.
  - `wr_sel` order 13, 10, 9 with matching data.
  - Addresses sp=0100/0102/0104.
  - Final sp=0106; `done` at cycle 14.
- POP R: mask 00FF.
  - 8 reads.
  - `wr_en` suppressed for index 4.
  - Final SP = start + 16.
- RET imm, with `STACK_POP_IMM_EN` defined: mask A000, sp=0200, imm=0006.
  - One read.
  - ADJ cycle observed.
  - `sp_out`=0208.
- Empty mask plus a `start` re-asserted while busy on another test:
  - Empty mask: `done` at cycle 2, no `mem_req`.
  - Extra `start` while busy: ignored.
- Reset asserted in REQ with `mem_req` high:
  - All outputs 0 asynchronously.
  - After release, a new `start` runs normally.

Source files
------------

// File: rtl/stack_pop_seq_pkg.sv
// stack_pop_seq_pkg
// Shared types for the stack pop sequencer (and the future push sequencer):
//   pop_state_e  - sequencer FSM encoding (IDLE, SCAN, REQ, ADJ, DONE)
//   stack_bit_e  - bit index of each STACK_* flag inside the 16-bit pop/push mask
//   sp_advance   - 16-bit stack pointer arithmetic (wraps modulo 2^16)
package stack_pop_seq_pkg;

  typedef enum logic [2:0] {
    POP_IDLE = 3'd0,
    POP_SCAN = 3'd1,
    POP_REQ  = 3'd2,
    POP_ADJ  = 3'd3,
    POP_DONE = 3'd4
  } pop_state_e;

  // Higher index is popped first: MODRM, PC, PS, PSW, IY ... AW.
  // Bits 8, 11 and 12 carry no register.
  typedef enum logic [3:0] {
    STACK_AW    = 4'd0,
    STACK_CW    = 4'd1,
    STACK_DW    = 4'd2,
    STACK_BW    = 4'd3,
    STACK_SP    = 4'd4,
    STACK_BP    = 4'd5,
    STACK_IX    = 4'd6,
    STACK_IY    = 4'd7,
    STACK_PSW   = 4'd9,
    STACK_PS    = 4'd10,
    STACK_PC    = 4'd13,
    STACK_MODRM = 4'd14,
    STACK_IMM   = 4'd15
  } stack_bit_e;

  // SP arithmetic is always 16-bit and wraps.
  function automatic logic [15:0] sp_advance(input logic [15:0] sp, input logic [15:0] delta);
    return sp + delta;
  endfunction

endpackage

// File: rtl/stack_pop_seq_mask_prio.sv
// stack_pop_seq_mask_prio
// Combinational highest-set-bit encoder over a 15-bit stack mask.
// Ports:
//   mask  in  15  candidate bits (bit 15 / STACK_IMM is never a register slot)
//   found out 1   at least one bit of mask is set
//   idx   out 4   index of the highest set bit (0 when found is 0)
module stack_pop_seq_mask_prio
  import stack_pop_seq_pkg::*;
(
  input  logic [14:0] mask,
  output logic        found,
  output logic [3:0]  idx
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 0; i < 15; i++) begin
      found = found | mask[i];
      idx   = mask[i] ? 4'(i) : idx;
    end
  end

endmodule

// File: rtl/stack_pop_seq.sv
// stack_pop_seq
// Multi-cycle stack pop sequencer. For each set bit of the pop mask (highest
// first) it issues one word read at SS:SP, forwards the word to the register
// file / MODRM writer and advances SP by 2. Finally it optionally adds the RET
// immediate to SP and strobes the final SP back.
//
// Configuration: define STACK_POP_IMM_EN to honour mask bit 15 (STACK_IMM) and
// the imm input via an extra ADJ cycle. Without it, bit 15 and imm are ignored.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start, pop_mask, ss,       sequence request and its operands (sampled in IDLE)
//   sp_in, imm
//   mem_req, mem_addr          word read request / physical address to the BIU
//   mem_ack, mem_rdata         read completion and data (same cycle)
//   wr_en, wr_sel, wr_data     popped-word write strobe, mask bit index, data
//   sp_out, sp_we              running SP and final-SP commit strobe
//   busy, done                 not-IDLE flag, completion pulse
module stack_pop_seq
  import stack_pop_seq_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       pop_mask,
  input  logic [15:0]       ss,
  input  logic [15:0]       sp_in,
  input  logic [15:0]       imm,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              wr_en,
  output logic [3:0]        wr_sel,
  output logic [15:0]       wr_data,
  output logic [15:0]       sp_out,
  output logic              sp_we,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] ST_IDLE = POP_IDLE;
  localparam logic [2:0] ST_SCAN = POP_SCAN;
  localparam logic [2:0] ST_REQ  = POP_REQ;
  localparam logic [2:0] ST_DONE = POP_DONE;
`ifdef STACK_POP_IMM_EN
  localparam logic [2:0] ST_ADJ  = POP_ADJ;
`endif

  // (ss << 4) + sp, both zero-extended, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return (ADDR_W'(seg) << 4) + ADDR_W'(off);
  endfunction

  logic [2:0]  state_r;
  logic [14:0] rem_r;
  logic [15:0] ss_r;
  logic [3:0]  cur_idx_r;
  logic        found_s;
  logic [3:0]  idx_s;

`ifdef STACK_POP_IMM_EN
  logic [15:0] imm_r;
  logic        imm_pend_r;
`else
  logic        unused_cfg_s;
  assign unused_cfg_s = ^{imm, pop_mask[15]};
`endif

  stack_pop_seq_mask_prio u_prio (
    .mask  (rem_r),
    .found (found_s),
    .idx   (idx_s)
  );

  // Sequencer FSM; every output is a flop. Strobes default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      rem_r      <= 15'd0;
      ss_r       <= 16'd0;
      cur_idx_r  <= 4'd0;
      mem_req    <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      wr_en      <= 1'b0;
      wr_sel     <= 4'd0;
      wr_data    <= 16'd0;
      sp_out     <= 16'd0;
      sp_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef STACK_POP_IMM_EN
      imm_r      <= 16'd0;
      imm_pend_r <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      sp_we <= 1'b0;
      done  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rem_r   <= pop_mask[14:0];
            ss_r    <= ss;
            sp_out  <= sp_in;
`ifdef STACK_POP_IMM_EN
            imm_r      <= imm;
            imm_pend_r <= pop_mask[15];
`endif
            busy    <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (found_s) begin
            mem_addr  <= phys_addr(ss_r, sp_out);
            mem_req   <= 1'b1;
            cur_idx_r <= idx_s;
            state_r   <= ST_REQ;
`ifdef STACK_POP_IMM_EN
          end else if (imm_pend_r) begin
            state_r <= ST_ADJ;
`endif
          end else begin
            sp_we   <= 1'b1;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // POP R reads the saved SP slot but must not overwrite SP.
            wr_en   <= (cur_idx_r != 4'(STACK_SP));
            wr_sel  <= cur_idx_r;
            wr_data <= mem_rdata;
            rem_r   <= rem_r & ~(15'd1 << cur_idx_r);
            sp_out  <= sp_advance(sp_out, 16'd2);
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_REQ;
          end
        end
`ifdef STACK_POP_IMM_EN
        ST_ADJ: begin
          sp_out     <= sp_advance(sp_out, imm_r);
          imm_pend_r <= 1'b0;
          sp_we      <= 1'b1;
          done       <= 1'b1;
          state_r    <= ST_DONE;
        end
`endif
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_pop_seq.sv
// Scoreboard bench for stack_pop_seq: each directed vector pushes expected
// addresses, writes and completion records; a negedge monitor compares them
// whenever the DUT presents mem_req, wr_en or done.
module tb_stack_pop_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pop_mask = 16'd0, ss = 16'd0, sp_in = 16'd0, imm = 16'd0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'd0;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data, sp_out;
  logic        sp_we, busy, done;

  stack_pop_seq #(.ADDR_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pop_mask(pop_mask),
    .ss(ss), .sp_in(sp_in), .imm(imm), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .sp_out(sp_out), .sp_we(sp_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] sel; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] sp; int cyc; } done_t;
  typedef struct { int waits; logic [15:0] data; } rsp_t;

  wr_t         exp_wr_q[$];
  done_t       exp_done_q[$];
  rsp_t        resp_q[$];
  logic [19:0] exp_addr_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int st_cyc = 0;
  int wait_left = -1;
  logic req_q = 1'b0;

  always @(posedge clk) cyc++;

  // Bus model: ack after the scripted number of wait states.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!reset_n) begin
      wait_left = -1;
    end else if (mem_req && resp_q.size() > 0) begin
      if (wait_left < 0) wait_left = resp_q[0].waits;
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = resp_q[0].data;
        void'(resp_q.pop_front());
        wait_left = -1;
      end else begin
        wait_left--;
      end
    end
  end

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      req_q = 1'b0;
    end else begin
      if (mem_req && !req_q) begin
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_req: mem_addr=%05h, none expected", mem_addr);
        end else begin
          logic [19:0] ea;
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            miscompares++;
            $display("FAIL mem_addr: got %05h want %05h", mem_addr, ea);
          end
        end
      end
      req_q = mem_req;
      if (wr_en) begin
        vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_wr: sel=%0d data=%04h, none expected", wr_sel, wr_data);
        end else begin
          wr_t ew;
          ew = exp_wr_q.pop_front();
          if (wr_sel !== ew.sel || wr_data !== ew.data) begin
            miscompares++;
            $display("FAIL wr: got sel=%0d data=%04h want sel=%0d data=%04h",
                     wr_sel, wr_data, ew.sel, ew.data);
          end
        end
      end
      if (done || sp_we) begin
        vectors++;
        if (exp_done_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: sp_out=%04h", sp_out);
        end else begin
          done_t ed;
          ed = exp_done_q.pop_front();
          if (sp_out !== ed.sp || done !== 1'b1 || sp_we !== 1'b1 || (cyc - st_cyc) != ed.cyc) begin
            miscompares++;
            $display("FAIL done: got sp=%04h done=%b sp_we=%b cyc=%0d want sp=%04h 1 1 cyc=%0d",
                     sp_out, done, sp_we, cyc - st_cyc, ed.sp, ed.cyc);
          end
        end
      end
    end
  end

  task automatic exp_pop(input logic [19:0] addr, input logic [3:0] sel,
                         input logic [15:0] data, input int waits, input bit wr);
    rsp_t r;
    wr_t  w;
    exp_addr_q.push_back(addr);
    r.waits = waits; r.data = data;
    resp_q.push_back(r);
    if (wr) begin
      w.sel = sel; w.data = data;
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic exp_done(input logic [15:0] sp, input int c);
    done_t d;
    d.sp = sp; d.cyc = c;
    exp_done_q.push_back(d);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({mem_req, wr_en, sp_we, done, busy, mem_addr, wr_sel, wr_data, sp_out} !== '0) begin
      miscompares++;
      $display("FAIL %s: req=%b wr_en=%b sp_we=%b done=%b busy=%b addr=%05h sel=%0d data=%04h sp=%04h want all 0",
               name, mem_req, wr_en, sp_we, done, busy, mem_addr, wr_sel, wr_data, sp_out);
    end
  endtask

  // Issue one sequence and wait (bounded) for its completion record.
  task automatic run(input string name, input logic [15:0] mask, input logic [15:0] ss_v,
                     input logic [15:0] sp_v, input logic [15:0] imm_v, input int extra_at);
    int n;
    @(negedge clk);
    start = 1'b1; pop_mask = mask; ss = ss_v; sp_in = sp_v; imm = imm_v; st_cyc = cyc;
    @(negedge clk);
    start = 1'b0; pop_mask = 16'hFFFF; ss = 16'hAAAA; sp_in = 16'h5555; imm = 16'h0F0F;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_c1: got %b want 1", name, busy);
    end
    n = 1;
    while (exp_done_q.size() != 0 && n < 300) begin
      if (n == extra_at) begin
        start = 1'b1; pop_mask = 16'h00FF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    vectors++;
    if (exp_done_q.size() != 0 || exp_addr_q.size() != 0 || exp_wr_q.size() != 0 || resp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: left done=%0d addr=%0d wr=%0d rsp=%0d want 0 0 0 0", name,
               exp_done_q.size(), exp_addr_q.size(), exp_wr_q.size(), resp_q.size());
      exp_done_q.delete(); exp_addr_q.delete(); exp_wr_q.delete(); resp_q.delete();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;

    // Single pop with SP wrap.
    exp_pop(20'h1FFFE, 4'd1, 16'hABCD, 0, 1'b1);
    exp_done(16'h0000, 4);
    run("single", 16'h0002, 16'h1000, 16'hFFFE, 16'h0000, 0);

    // RETI, 2 wait states each, stray start while busy.
    exp_pop(20'h30100, 4'd13, 16'h1111, 2, 1'b1);
    exp_pop(20'h30102, 4'd10, 16'h2222, 2, 1'b1);
    exp_pop(20'h30104, 4'd9,  16'h3333, 2, 1'b1);
    exp_done(16'h0106, 14);
    run("reti", 16'h2600, 16'h3000, 16'h0100, 16'h0000, 5);

    // POP R: eight reads, SP slot discarded, SP wraps through 0000.
    exp_pop(20'h104F8, 4'd7, 16'hA007, 0, 1'b1);
    exp_pop(20'h104FA, 4'd6, 16'hA006, 0, 1'b1);
    exp_pop(20'h104FC, 4'd5, 16'hA005, 1, 1'b1);
    exp_pop(20'h104FE, 4'd4, 16'hA004, 0, 1'b0);
    exp_pop(20'h00500, 4'd3, 16'hA003, 0, 1'b1);
    exp_pop(20'h00502, 4'd2, 16'hA002, 0, 1'b1);
    exp_pop(20'h00504, 4'd1, 16'hA001, 0, 1'b1);
    exp_pop(20'h00506, 4'd0, 16'hA000, 0, 1'b1);
    exp_done(16'h0008, 19);
    run("popr", 16'h00FF, 16'h0050, 16'hFFF8, 16'h0000, 0);

    // Empty mask.
    exp_done(16'h1234, 2);
    run("empty", 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0);

    // RET imm and imm-only mask.
    exp_pop(20'h00200, 4'd13, 16'hBEEF, 0, 1'b1);
`ifdef STACK_POP_IMM_EN
    exp_done(16'h0208, 5);
`else
    exp_done(16'h0202, 4);
`endif
    run("ret_imm", 16'hA000, 16'h0000, 16'h0200, 16'h0006, 0);
`ifdef STACK_POP_IMM_EN
    exp_done(16'h0310, 3);
`else
    exp_done(16'h0300, 2);
`endif
    run("imm_only", 16'h8000, 16'h0000, 16'h0300, 16'h0010, 0);

    // Physical address wrap: FFFF:0010 -> 00000.
    exp_pop(20'h00000, 4'd0, 16'h5A5A, 0, 1'b1);
    exp_done(16'h0012, 4);
    run("addr_wrap", 16'h0001, 16'hFFFF, 16'h0010, 16'h0000, 0);

    // Reset while a request is outstanding.
    exp_pop(20'h00400, 4'd0, 16'h7777, 20, 1'b1);
    @(negedge clk);
    start = 1'b1; pop_mask = 16'h0001; ss = 16'h0000; sp_in = 16'h0400; st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!mem_req) begin
      miscompares++;
      $display("FAIL rst_req_wait: mem_req got 0 want 1");
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    resp_q.delete(); exp_wr_q.delete(); exp_done_q.delete(); exp_addr_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    exp_pop(20'h20010, 4'd2, 16'hC0DE, 1, 1'b1);
    exp_done(16'h0012, 5);
    run("after_reset", 16'h0004, 16'h2000, 16'h0010, 16'h0000, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
